// File: rtl/fb_pkg.sv
// Shared constants, types and the pixel-to-address mapping for the framebuffer write port.
package fb_pkg;

   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned V_TOTAL     = 521;
   localparam int unsigned CLEAR_WORDS = 416800;
   localparam int unsigned FB_ADDR_W   = 19;
   localparam int unsigned FB_DATA_W   = 16;
   localparam int unsigned PIX_COORD_W = 10;
   localparam int unsigned FIFO_DEPTH  = 8;
   localparam int unsigned FIFO_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FIFO_CNT_W  = FIFO_PTR_W + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } fb_state_e;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [FB_DATA_W-1:0] data;
   } fb_pix_t;

   // y*800 + x as shift-and-add: 800 = 512 + 256 + 32.
   function automatic logic [FB_ADDR_W-1:0] fb_lin_addr(
      input logic [PIX_COORD_W-1:0] x,
      input logic [PIX_COORD_W-1:0] y
   );
      logic [FB_ADDR_W-1:0] yw;
      yw = FB_ADDR_W'(y);
      return (yw << 9) + (yw << 8) + (yw << 5) + FB_ADDR_W'(x);
   endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Small synchronous FIFO of {addr,data} pixel writes; head entry is read combinationally.
module fb_pixel_fifo
   import fb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  fb_pix_t               wr_entry,
   output fb_pix_t               head_c,
   output logic                  empty_q,
   output logic                  full_q,
   output logic [FIFO_CNT_W-1:0] count_q,
   output logic [FIFO_CNT_W-1:0] count_nxt_c
);

   fb_pix_t               mem_q [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_CNT_W-1:0] count_d;
   logic                  empty_d, full_d;
   logic                  push_ok, pop_ok;

   assign push_ok     = push && !full_q;
   assign pop_ok      = pop && !empty_q;
   assign head_c      = mem_q[rd_ptr_q];
   assign count_nxt_c = count_d;

   // Pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + FIFO_CNT_W'(1);
         2'b01:   count_d = count_q - FIFO_CNT_W'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == FIFO_CNT_W'(0));
      full_d  = (count_d == FIFO_CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write port: maps pixels to linear addresses, queues them, runs clear sweeps
// and arbitrates the single SRAM port against VGA scan-out.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int unsigned CLEAR_LEN = CLEAR_WORDS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_start,
   input  logic [FB_DATA_W-1:0]   clear_value,
   input  logic                   pix_valid,
   output logic                   pix_ready,
   input  logic [PIX_COORD_W-1:0] pix_x,
   input  logic [PIX_COORD_W-1:0] pix_y,
   input  logic [FB_DATA_W-1:0]   pix_color,
   input  logic                   scan_en,
   input  logic [FB_ADDR_W-1:0]   scan_addr,
   output logic                   sram_wren,
   output logic [FB_ADDR_W-1:0]   sram_addr,
   output logic [FB_DATA_W-1:0]   sram_d,
   output logic                   busy,
   output logic                   clear_done,
   output logic                   oob_flag
);

   fb_state_e             state_q, state_d;
   logic [FB_ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic                  sram_wren_q, sram_wren_d;
   logic [FB_ADDR_W-1:0]  sram_addr_q, sram_addr_d;
   logic [FB_DATA_W-1:0]  sram_d_q, sram_d_d;
   logic                  busy_q, busy_d;
   logic                  clear_done_q, clear_done_d;
   logic                  oob_flag_q, oob_flag_d;
   logic                  pix_ready_q, pix_ready_d;

   logic                  accept, in_range, fifo_push, fifo_pop, clr_last;
   fb_pix_t               fifo_wr, fifo_head;
   logic                  fifo_empty, fifo_full;
   logic [FIFO_CNT_W-1:0] fifo_count, fifo_count_nxt;

   assign in_range  = (pix_x < PIX_COORD_W'(H_TOTAL)) && (pix_y < PIX_COORD_W'(V_TOTAL));
   assign accept    = pix_valid && pix_ready_q;
   assign fifo_push = accept && in_range;
   assign clr_last  = (clr_cnt_q == FB_ADDR_W'(CLEAR_LEN - 1));

   always_comb begin
      fifo_wr      = '0;
      fifo_wr.addr = fb_lin_addr(pix_x, pix_y);
      fifo_wr.data = pix_color;
   end

   fb_pixel_fifo u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (fifo_push),
      .pop         (fifo_pop),
      .wr_entry    (fifo_wr),
      .head_c      (fifo_head),
      .empty_q     (fifo_empty),
      .full_q      (fifo_full),
      .count_q     (fifo_count),
      .count_nxt_c (fifo_count_nxt)
   );

   // FSM, clear counter and SRAM arbiter; scan-out wins, then clear, then the FIFO.
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      sram_wren_d  = 1'b0;
      sram_addr_d  = sram_addr_q;
      sram_d_d     = sram_d_q;
      clear_done_d = 1'b0;
      fifo_pop     = 1'b0;
      oob_flag_d   = oob_flag_q || (accept && !in_range);

      case (state_q)
         ST_IDLE: begin
            if (clear_start) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            if (!scan_en) begin
               if (clr_last) begin
                  state_d      = ST_IDLE;
                  clear_done_d = 1'b1;
               end else begin
                  clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (scan_en) begin
         sram_addr_d = scan_addr;
      end else if (state_q == ST_CLEAR) begin
         sram_wren_d = 1'b1;
         sram_addr_d = clr_cnt_q;
         sram_d_d    = clear_value;
      end else if (!fifo_empty) begin
         fifo_pop    = 1'b1;
         sram_wren_d = 1'b1;
         sram_addr_d = fifo_head.addr;
         sram_d_d    = fifo_head.data;
      end

      busy_d      = (state_d == ST_CLEAR) || (fifo_count_nxt != FIFO_CNT_W'(0));
      pix_ready_d = (fifo_count_nxt < FIFO_CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         clr_cnt_q    <= '0;
         sram_wren_q  <= 1'b0;
         sram_addr_q  <= '0;
         sram_d_q     <= '0;
         busy_q       <= 1'b0;
         clear_done_q <= 1'b0;
         oob_flag_q   <= 1'b0;
         pix_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         sram_wren_q  <= sram_wren_d;
         sram_addr_q  <= sram_addr_d;
         sram_d_q     <= sram_d_d;
         busy_q       <= busy_d;
         clear_done_q <= clear_done_d;
         oob_flag_q   <= oob_flag_d;
         pix_ready_q  <= pix_ready_d;
      end
   end

   assign sram_wren  = sram_wren_q;
   assign sram_addr  = sram_addr_q;
   assign sram_d     = sram_d_q;
   assign busy       = busy_q;
   assign clear_done = clear_done_q;
   assign oob_flag   = oob_flag_q;
   assign pix_ready  = pix_ready_q;

   // Occupancy count and full flag are carried in pix_ready/busy; kept for debug visibility.
   logic unused_ok;
   assign unused_ok = ^{fifo_count, fifo_full};

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomized bench for fb_pixel_writer against a queue-based reference of the write port.
module tb_fb_pixel_writer;
   import fb_pkg::*;

   localparam int unsigned TB_CLEAR = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_start;
   logic [15:0] clear_value;
   logic        pix_valid;
   logic        pix_ready;
   logic [9:0]  pix_x, pix_y;
   logic [15:0] pix_color;
   logic        scan_en;
   logic [18:0] scan_addr;
   logic        sram_wren;
   logic [18:0] sram_addr;
   logic [15:0] sram_d;
   logic        busy, clear_done, oob_flag;

   always #5 clk = ~clk;

   fb_pixel_writer #(.CLEAR_LEN(TB_CLEAR)) dut (
      .clk(clk), .rst(rst), .clear_start(clear_start), .clear_value(clear_value),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .pix_color(pix_color), .scan_en(scan_en), .scan_addr(scan_addr),
      .sram_wren(sram_wren), .sram_addr(sram_addr), .sram_d(sram_d),
      .busy(busy), .clear_done(clear_done), .oob_flag(oob_flag)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: pending writes in a queue, clear sweep as a plain next-address counter.
   logic [34:0] mq[$];
   bit          m_clr;
   int unsigned m_cnt;
   logic        m_wren, m_done, m_oob;
   logic [18:0] m_addr;
   logic [15:0] m_d;

   always @(posedge clk or posedge rst) begin
      bit          pre_clr;
      bit          acc;
      int          pre_sz;
      int unsigned lin;
      logic [34:0] e;
      if (rst) begin
         mq.delete();
         m_clr = 0; m_cnt = 0; m_wren = 0; m_addr = '0; m_d = '0; m_done = 0; m_oob = 0;
      end else begin
         pre_clr = m_clr;
         pre_sz  = mq.size();
         acc     = pix_valid && (pre_sz < int'(FIFO_DEPTH));
         m_wren  = 0;
         m_done  = 0;
         if (scan_en) begin
            m_addr = scan_addr;
         end else if (pre_clr) begin
            m_wren = 1; m_addr = 19'(m_cnt); m_d = clear_value;
            if (m_cnt == TB_CLEAR - 1) begin m_clr = 0; m_done = 1; end
            else m_cnt++;
         end else if (pre_sz > 0) begin
            e = mq.pop_front();
            m_wren = 1; m_addr = e[34:16]; m_d = e[15:0];
         end
         if (clear_start && !pre_clr) begin m_clr = 1; m_cnt = 0; end
         if (acc) begin
            if (int'(pix_x) < int'(H_TOTAL) && int'(pix_y) < int'(V_TOTAL)) begin
               lin = int'(pix_y) * H_TOTAL + int'(pix_x);
               mq.push_back({19'(lin), pix_color});
            end else begin
               m_oob = 1;
            end
         end
      end
   end

   bit          chk_en = 0;
   int unsigned n_done = 0, n_wr = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wren",  32'(sram_wren),  32'(m_wren));
         chk("addr",  32'(sram_addr),  32'(m_addr));
         chk("data",  32'(sram_d),     32'(m_d));
         chk("done",  32'(clear_done), 32'(m_done));
         chk("oob",   32'(oob_flag),   32'(m_oob));
         chk("ready", 32'(pix_ready),  32'(mq.size() < int'(FIFO_DEPTH)));
         chk("busy",  32'(busy),       32'(m_clr || mq.size() != 0));
         if (clear_done) n_done++;
         if (sram_wren)  n_wr++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle(input string tag, input int bound);
      for (int i = 0; i < bound && busy; i++) cyc(1);
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic set_pix(input int x, input int y, input int c);
      pix_x = 10'(x); pix_y = 10'(y); pix_color = 16'(c);
   endtask

   int unsigned wr0, done0, idx;
   bit          r;
   logic [9:0]  px [9];
   logic [9:0]  py [9];

   initial begin
      rst = 1; clear_start = 0; clear_value = '0; pix_valid = 0;
      pix_x = '0; pix_y = '0; pix_color = '0; scan_en = 0; scan_addr = '0;
      chk_en = 1;
      cyc(3);
      rst = 0;
      chk("rst_wren",  32'(sram_wren), 0);
      chk("rst_addr",  32'(sram_addr), 0);
      chk("rst_ready", 32'(pix_ready), 1);
      chk("rst_busy",  32'(busy), 0);

      // Single pixel latency and mapping
      pix_valid = 1; set_pix(3, 2, 350);
      cyc(1);
      pix_valid = 0;
      cyc(1);
      chk("t1_wren", 32'(sram_wren), 1);
      chk("t1_addr", 32'(sram_addr), 1603);
      chk("t1_data", 32'(sram_d), 350);
      cyc(2);

      // Clear sweep with a scan-out window and an ignored restart
      wr0 = n_wr; done0 = n_done;
      clear_value = 16'($urandom);
      clear_start = 1; cyc(1); clear_start = 0;
      cyc(300);
      scan_en = 1;
      repeat (10) begin scan_addr = 19'($urandom); cyc(1); end
      scan_en = 0;
      cyc(20);
      clear_start = 1; cyc(1); clear_start = 0;
      wait_idle("t2_idle", TB_CLEAR + 100);
      cyc(2);
      chk("t2_writes", n_wr - wr0, TB_CLEAR);
      chk("t2_done_cnt", n_done - done0, 1);

      // Nine pixels back-to-back while scan-out holds the SRAM
      for (int i = 0; i < 9; i++) begin
         px[i] = 10'($urandom_range(0, 799));
         py[i] = 10'($urandom_range(0, 520));
      end
      scan_en = 1; pix_valid = 1; idx = 0;
      for (int c = 0; c < 12; c++) begin
         scan_addr = 19'($urandom);
         set_pix(int'(px[idx]), int'(py[idx]), int'($urandom_range(0, 65535)));
         r = pix_ready;
         cyc(1);
         if (r) idx++;
      end
      chk("t4_accepted", idx, 8);
      chk("t4_full", 32'(pix_ready), 0);
      scan_en = 0;
      r = 0;
      for (int c = 0; c < 30 && !r; c++) begin r = pix_ready; cyc(1); end
      pix_valid = 0;
      chk("t4_ninth", 32'(r), 1);
      wait_idle("t4_idle", 50);
      cyc(2);

      // Out-of-range pixels are dropped and flagged
      wr0 = n_wr;
      pix_valid = 1; set_pix(800, 0, 7); cyc(1);
      set_pix(0, 521, 9); cyc(1);
      pix_valid = 0;
      cyc(3);
      chk("t5_oob", 32'(oob_flag), 1);
      chk("t5_nowrite", n_wr - wr0, 0);

      // Reset mid-clear with queued pixels
      clear_start = 1; cyc(1); clear_start = 0;
      cyc(50);
      pix_valid = 1;
      for (int i = 0; i < 3; i++) begin set_pix(i, i, 100 + i); cyc(1); end
      pix_valid = 0;
      cyc(5);
      @(posedge clk); #3;
      rst = 1; #1;
      chk("t6_wren",  32'(sram_wren), 0);
      chk("t6_addr",  32'(sram_addr), 0);
      chk("t6_data",  32'(sram_d), 0);
      chk("t6_busy",  32'(busy), 0);
      chk("t6_done",  32'(clear_done), 0);
      chk("t6_oob",   32'(oob_flag), 0);
      chk("t6_ready", 32'(pix_ready), 1);
      cyc(2);
      rst = 0;
      wr0 = n_wr;
      cyc(20);
      chk("t6_nowrite", n_wr - wr0, 0);

      // Random traffic with scan-out contention and one clear sweep
      for (int c = 0; c < 4000; c++) begin
         scan_en     = ($urandom_range(0, 3) == 0);
         scan_addr   = 19'($urandom);
         pix_valid   = ($urandom_range(0, 2) != 0);
         clear_start = (c == 1500) || ($urandom_range(0, 1999) == 0);
         clear_value = 16'($urandom);
         if ($urandom_range(0, 15) == 0)
            set_pix(int'($urandom_range(800, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 65535)));
         else
            set_pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 520)), int'($urandom_range(0, 65535)));
         cyc(1);
      end
      pix_valid = 0; scan_en = 0; clear_start = 0;
      wait_idle("t7_idle", 3 * TB_CLEAR);
      cyc(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
